regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_clr_fsm.sv | 54 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 5;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write, pending-mark and bulk-clear signals of the register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic [1:0]               wr_en;
  logic [2*ADDR_W-1:0]      wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_req,
    input  rd_data, rd_pend, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_req,
    output rd_data, rd_pend, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks registers 1..DEPTH-1, then pulses clr_done.
module regfile_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_active,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q  <= StClear;
            clr_idx  <= ADDR_W'(1);
            clr_busy <= 1'b1;
          end
        end
        StClear: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          // Last register of the array is being zeroed this cycle.
          if (clr_idx == '1) begin
            state_q  <= StDone;
            clr_done <= 1'b1;
          end
        end
        StDone: begin
          state_q  <= StIdle;
          clr_idx  <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clr_active = (state_q == StClear);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-producer bits, write bypass and bulk clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic              clr_busy;
  logic              clr_done;
  logic              clr_active;
  logic [ADDR_W-1:0] clr_idx;

  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      wa[i] = bus.wr_addr[i*ADDR_W +: ADDR_W];
      wd[i] = bus.wr_data[i*DATA_W +: DATA_W];
    end
  end

  regfile_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (bus.clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_active(clr_active),
    .clr_idx   (clr_idx)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

  // Port 1 is applied after port 0 so it wins on an address collision;
  // pend_set is applied last so it survives a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      pend_q <= '0;
    end else if (clr_active) begin
      mem_q[clr_idx]  <= '0;
      pend_q[clr_idx] <= 1'b0;
    end else if (!clr_busy) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (bus.wr_en[i] && wa[i] != '0) begin
          mem_q[wa[i]]  <= wd[i];
          pend_q[wa[i]] <= 1'b0;
        end
      end
      if (bus.pend_set && bus.pend_addr != '0) begin
        pend_q[bus.pend_addr] <= 1'b1;
      end
    end
  end

  logic [NUM_RD*DATA_W-1:0] rd_data_d;
  logic [NUM_RD-1:0]        rd_pend_d;
  logic [ADDR_W-1:0]        ra;

  always_comb begin
    rd_data_d = '0;
    rd_pend_d = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (rst_n && ra != '0) begin
        rd_data_d[k*DATA_W +: DATA_W] = mem_q[ra];
        rd_pend_d[k]                  = pend_q[ra];
        if (BYPASS != 0 && !clr_busy) begin
          for (int unsigned i = 0; i < 2; i++) begin
            if (bus.wr_en[i] && wa[i] == ra) begin
              rd_data_d[k*DATA_W +: DATA_W] = wd[i];
              rd_pend_d[k]                  = bus.pend_set && (bus.pend_addr == ra);
            end
          end
        end
      end
    end
  end

  assign bus.rd_data = rd_data_d;
  assign bus.rd_pend = rd_pend_d;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances checked against a behavioural model.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int          DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

  assign bus_n.rd_addr   = bus_b.rd_addr;
  assign bus_n.wr_en     = bus_b.wr_en;
  assign bus_n.wr_addr   = bus_b.wr_addr;
  assign bus_n.wr_data   = bus_b.wr_data;
  assign bus_n.pend_set  = bus_b.pend_set;
  assign bus_n.pend_addr = bus_b.pend_addr;
  assign bus_n.clr_req   = bus_b.clr_req;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut_byp (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nob (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: register contents, pending bits, cycles into a clear (-1 = idle).
  logic [31:0] m_mem  [DEPTH];
  bit          m_pend [DEPTH];
  int          t_clr;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_pd0;
    logic        e_pd1;
    logic [31:0] n_rd0;
    logic        n_pd0;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    t_clr = -1;
  endtask

  task automatic set_in(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1, input logic ps,
                        input logic [4:0] pa, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic clr);
    bus_b.wr_en     = we;
    bus_b.wr_addr   = {wa1, wa0};
    bus_b.wr_data   = {wd1, wd0};
    bus_b.pend_set  = ps;
    bus_b.pend_addr = pa;
    bus_b.rd_addr   = {ra1, ra0};
    bus_b.clr_req   = clr;
  endtask

  task automatic set_idle();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Expected combinational read of address a given current inputs and model state.
  task automatic exp_read(input logic [4:0] a, input bit byp, output logic [31:0] d,
                          output logic p);
    logic [4:0] wa [2];
    wa[0] = bus_b.wr_addr[4:0];
    wa[1] = bus_b.wr_addr[9:5];
    d = '0;
    p = 1'b0;
    if (!rst_n || a == 5'd0) return;
    d = m_mem[a];
    p = m_pend[a];
    if (byp && t_clr < 0) begin
      for (int i = 0; i < 2; i++) begin
        if (bus_b.wr_en[i] && wa[i] == a) begin
          d = bus_b.wr_data[i*32 +: 32];
          p = bus_b.pend_set && bus_b.pend_addr == a;
        end
      end
    end
  endtask

  task automatic model_tick();
    logic [4:0] wa [2];
    wa[0] = bus_b.wr_addr[4:0];
    wa[1] = bus_b.wr_addr[9:5];
    if (t_clr >= 0) begin
      if (t_clr < DEPTH - 1) begin
        m_mem[t_clr+1]  = '0;
        m_pend[t_clr+1] = 1'b0;
        t_clr++;
      end else begin
        t_clr = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus_b.wr_en[i] && wa[i] != 5'd0) begin
          m_mem[wa[i]]  = bus_b.wr_data[i*32 +: 32];
          m_pend[wa[i]] = 1'b0;
        end
      end
      if (bus_b.pend_set && bus_b.pend_addr != 5'd0) m_pend[bus_b.pend_addr] = 1'b1;
      if (bus_b.clr_req) t_clr = 0;
    end
  endtask

  task automatic check_outputs();
    logic [4:0]  a;
    logic [31:0] d;
    logic        p;
    for (int k = 0; k < 2; k++) begin
      a = bus_b.rd_addr[k*5 +: 5];
      exp_read(a, 1'b1, d, p);
      chk($sformatf("byp rd_data%0d a=%0d", k, a), 64'(bus_b.rd_data[k*32 +: 32]), 64'(d));
      chk($sformatf("byp rd_pend%0d a=%0d", k, a), 64'(bus_b.rd_pend[k]), 64'(p));
      exp_read(a, 1'b0, d, p);
      chk($sformatf("nob rd_data%0d a=%0d", k, a), 64'(bus_n.rd_data[k*32 +: 32]), 64'(d));
      chk($sformatf("nob rd_pend%0d a=%0d", k, a), 64'(bus_n.rd_pend[k]), 64'(p));
    end
    chk("clr_busy", 64'(bus_b.clr_busy), 64'(t_clr >= 0 && rst_n));
    chk("clr_done", 64'(bus_b.clr_done), 64'(t_clr == DEPTH - 1 && rst_n));
    chk("nob clr_busy", 64'(bus_n.clr_busy), 64'(t_clr >= 0 && rst_n));
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic fill_all();
    for (int i = 1; i < DEPTH; i++) begin
      set_in(2'b01, 5'(i), $urandom | 32'h1, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i - 1), 1'b0);
      step();
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
      @(negedge clk);
      check_outputs();
      chk({tag, " zero rd_data"}, 64'(bus_b.rd_data), 64'd0);
      chk({tag, " zero rd_pend"}, 64'(bus_b.rd_pend), 64'd0);
      @(posedge clk);
      model_tick();
      #1;
    end
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    vec[0] = '{2'b11, 5'd5, 32'h1234, 5'd5, 32'hABCD, 1'b0, 5'd0, 5'd5, 5'd0,
               32'hABCD, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
               32'hABCD, 32'hABCD, 1'b0, 1'b0, 32'hABCD, 1'b0};
    vec[2] = '{2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[4] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5,
               32'h0, 32'hABCD, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
               32'h0, 32'hABCD, 1'b1, 1'b0, 32'h0, 1'b1};
    vec[6] = '{2'b01, 5'd7, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
               32'h55, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
    vec[7] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
               32'h55, 32'hABCD, 1'b0, 1'b0, 32'h55, 1'b0};
    vec[8] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h10, 1'b1, 5'd9, 5'd9, 5'd7,
               32'h10, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0};
    vec[9] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5,
               32'h10, 32'hABCD, 1'b1, 1'b0, 32'h10, 1'b1};

    model_reset();
    set_in(2'b11, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 1'b0, 5'd0, 5'd3, 5'd4, 1'b0);
    #2;
    chk("reset rd_data", 64'(bus_b.rd_data), 64'd0);
    chk("reset rd_pend", 64'(bus_b.rd_pend), 64'd0);
    chk("reset clr_busy", 64'(bus_b.clr_busy), 64'd0);
    chk("reset clr_done", 64'(bus_b.clr_done), 64'd0);
    check_outputs();
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    @(posedge clk);
    model_tick();
    #1;

    // Directed vectors: same-address write collision, r0, pending/bypass interplay.
    for (int i = 0; i < 10; i++) begin
      set_in(vec[i].we, vec[i].wa0, vec[i].wd0, vec[i].wa1, vec[i].wd1, vec[i].ps, vec[i].pa,
             vec[i].ra0, vec[i].ra1, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d byp rd0", i), 64'(bus_b.rd_data[31:0]), 64'(vec[i].e_rd0));
      chk($sformatf("vec%0d byp rd1", i), 64'(bus_b.rd_data[63:32]), 64'(vec[i].e_rd1));
      chk($sformatf("vec%0d byp pd0", i), 64'(bus_b.rd_pend[0]), 64'(vec[i].e_pd0));
      chk($sformatf("vec%0d byp pd1", i), 64'(bus_b.rd_pend[1]), 64'(vec[i].e_pd1));
      chk($sformatf("vec%0d nob rd0", i), 64'(bus_n.rd_data[31:0]), 64'(vec[i].n_rd0));
      chk($sformatf("vec%0d nob pd0", i), 64'(bus_n.rd_pend[0]), 64'(vec[i].n_pd0));
      check_outputs();
      @(posedge clk);
      model_tick();
      #1;
    end

    // Full clear with writes, pend_set and repeated clr_req thrown at it while busy.
    fill_all();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31, 1'b1);
    step();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      set_in(2'($urandom_range(0, 3)), raddr(), $urandom, raddr(), $urandom,
             1'($urandom_range(0, 1)), raddr(), raddr(), raddr(), c < 20);
      @(negedge clk);
      check_outputs();
      if (bus_b.clr_busy) busy_cnt++;
      if (bus_b.clr_done) done_cnt++;
      if (!bus_b.clr_busy) begin
        set_idle();
        @(posedge clk);
        model_tick();
        #1;
        break;
      end
      @(posedge clk);
      model_tick();
      #1;
    end
    chk("clear busy cycles", 64'(busy_cnt), 64'(DEPTH));
    chk("clear done pulses", 64'(done_cnt), 64'd1);
    sweep_zero("after clear");

    // Reset while the clear is at index 10.
    fill_all();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
    set_idle();
    for (int c = 0; c < 9; c++) step();
    chk("mid-clear busy before reset", 64'(bus_b.clr_busy), 64'd1);
    #2;
    set_in(2'b11, 5'd3, 32'hAAAA, 5'd4, 32'hBBBB, 1'b1, 5'd3, 5'd3, 5'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort clr_busy", 64'(bus_b.clr_busy), 64'd0);
    chk("abort clr_done", 64'(bus_b.clr_done), 64'd0);
    chk("abort rd_data", 64'(bus_b.rd_data), 64'd0);
    chk("abort rd_pend", 64'(bus_b.rd_pend), 64'd0);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    @(posedge clk);
    model_tick();
    #1;
    sweep_zero("after abort");
    set_in(2'b01, 5'd3, 32'h77, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0);
    @(negedge clk);
    chk("r3 readback", 64'(bus_b.rd_data[31:0]), 64'h77);
    chk("r3 readback nob", 64'(bus_n.rd_data[31:0]), 64'h77);
    check_outputs();
    @(posedge clk);
    model_tick();
    #1;

    // Randomised traffic with occasional clear requests.
    for (int c = 0; c < 1500; c++) begin
      set_in(2'($urandom_range(0, 3)), raddr(), $urandom, raddr(), $urandom,
             1'($urandom_range(0, 3) == 0), raddr(), raddr(), raddr(),
             $urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
